lcd: RTL and testbench

- HD44780-compatible character LCD controller driving the display in 4-bit mode.
- After reset it autonomously runs the power-on initialisation sequence.
- It then accepts one byte per start handshake, either a command (rs_in=0) or a character (rs_in=1), and splits it into two nibble writes with correct enable timing and execution delays.
- Sits between the application logic (sensor readout / text formatter) and the LCD pins.

---
 rtl/lcd.sv | 192 +++++++++++++++++++
 tb/tb_lcd.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd.sv
// rtl/lcd.sv - HD44780 4-bit character LCD controller with autonomous power-on init
module lcd #(
    parameter int unsigned CLK_FREQ_HZ   = 12_000_000,
    parameter int unsigned POWERUP_CYC   = 480_000,
    parameter int unsigned INIT1_CYC     = 49_200,
    parameter int unsigned INIT2_CYC     = 1_200,
    parameter int unsigned E_SETUP_CYC   = 1,
    parameter int unsigned E_HIGH_CYC    = 6,
    parameter int unsigned NIB_GAP_CYC   = 12,
    parameter int unsigned EXEC_CYC      = 600,
    parameter int unsigned LONG_EXEC_CYC = 24_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs_in,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [3:0] data_out,
    output logic       rs_out,
    output logic       enable_out,
    output logic       busy
);

    if (CLK_FREQ_HZ == 0 || E_SETUP_CYC == 0 || E_HIGH_CYC == 0 || NIB_GAP_CYC == 0) begin : g_bad_params
        $error("lcd: clock and pulse timing parameters must be non-zero");
    end

    typedef enum logic [2:0] {
        POWER_WAIT, INIT_STEP, SETUP, E_HIGH, E_LOW, EXEC_WAIT, IDLE
    } state_t;

    // Counter load values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [18:0] POWER_LD = 19'(POWERUP_CYC - 1);
    localparam logic [18:0] INIT1_LD = 19'(INIT1_CYC - 1);
    localparam logic [18:0] INIT2_LD = 19'(INIT2_CYC - 1);
    localparam logic [18:0] SETUP_LD = 19'(E_SETUP_CYC - 1);
    localparam logic [18:0] FIRST_LD = 19'(E_SETUP_CYC);
    localparam logic [18:0] EHI_LD   = 19'(E_HIGH_CYC - 1);
    localparam logic [18:0] GAP_LD   = 19'(NIB_GAP_CYC - 1);
    localparam logic [18:0] EXEC_LD  = 19'(EXEC_CYC - 1);
    localparam logic [18:0] LONG_LD  = 19'(LONG_EXEC_CYC - 1);

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  byte_q, byte_d;
    logic        rs_q, rs_d;
    logic        low_q, low_d;
    logic        single_q, single_d;
    logic        init_q, init_d;
    logic [3:0]  data_out_q, data_out_d;
    logic        rs_out_q, rs_out_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic [18:0] wait_ld;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= POWER_WAIT;
            cnt_q      <= POWER_LD;
            step_q     <= 3'd0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            low_q      <= 1'b0;
            single_q   <= 1'b0;
            init_q     <= 1'b1;
            data_out_q <= 4'h0;
            rs_out_q   <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            low_q      <= low_d;
            single_q   <= single_d;
            init_q     <= init_d;
            data_out_q <= data_out_d;
            rs_out_q   <= rs_out_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
        end
    end

    // Post-nibble wait: init nibbles use the fixed init delays, bytes depend on the instruction.
    always_comb begin
        wait_ld = EXEC_LD;
        if (single_q) begin
            wait_ld = (step_q == 3'd0) ? INIT1_LD : INIT2_LD;
        end else if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03)) begin
            wait_ld = LONG_LD;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        low_d    = low_q;
        single_d = single_q;
        init_d   = init_q;
        if (cnt_q != 19'd0 && state_q != IDLE && state_q != INIT_STEP) begin
            cnt_d = cnt_q - 19'd1;
        end else begin
            case (state_q)
                POWER_WAIT: state_d = INIT_STEP;
                INIT_STEP: begin
                    // Steps 0-3 are lone nibbles (carried in the high half), 4-7 full bytes.
                    rs_d    = 1'b0;
                    low_d   = 1'b0;
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    if (step_q < 3'd4) begin
                        single_d = 1'b1;
                        byte_d   = (step_q == 3'd3) ? 8'h20 : 8'h30;
                    end else begin
                        single_d = 1'b0;
                        case (step_q[1:0])
                            2'd0:    byte_d = 8'h28;
                            2'd1:    byte_d = 8'h0C;
                            2'd2:    byte_d = 8'h06;
                            default: byte_d = 8'h01;
                        endcase
                    end
                end
                SETUP: begin
                    state_d = E_HIGH;
                    cnt_d   = EHI_LD;
                end
                E_HIGH: begin
                    state_d = E_LOW;
                    cnt_d   = GAP_LD;
                end
                E_LOW: begin
                    if (!low_q && !single_q) begin
                        low_d   = 1'b1;
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = EXEC_WAIT;
                        cnt_d   = wait_ld;
                    end
                end
                EXEC_WAIT: begin
                    if (init_q && step_q != 3'd7) begin
                        step_d  = step_q + 3'd1;
                        state_d = INIT_STEP;
                    end else begin
                        init_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (start) begin
                        byte_d   = data_in;
                        rs_d     = rs_in;
                        low_d    = 1'b0;
                        single_d = 1'b0;
                        state_d  = SETUP;
                        cnt_d    = FIRST_LD;
                    end
                end
                default: begin
                    state_d = POWER_WAIT;
                    cnt_d   = POWER_LD;
                end
            endcase
        end
    end

    // Bus changes once per nibble, when the remaining setup time equals E_SETUP_CYC.
    always_comb begin
        data_out_d = data_out_q;
        rs_out_d   = rs_out_q;
        if (state_d == SETUP && cnt_d == SETUP_LD) begin
            data_out_d = low_d ? byte_d[3:0] : byte_d[7:4];
            rs_out_d   = rs_d;
        end
        enable_d = (state_d == E_HIGH);
        busy_d   = (state_d != IDLE);
    end

    assign data_out   = data_out_q;
    assign rs_out     = rs_out_q;
    assign enable_out = enable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lcd.sv
// tb/tb_lcd.sv - randomized self-checking bench for the lcd controller
module tb_lcd;

    localparam int P_POWERUP = 300;
    localparam int P_INIT1   = 100;
    localparam int P_INIT2   = 40;
    localparam int P_SETUP   = 1;
    localparam int P_HIGH    = 6;
    localparam int P_GAP     = 12;
    localparam int P_EXEC    = 600;
    localparam int P_LONG    = 2400;
    localparam int BOUND     = 30000;

    logic       clk;
    logic       rst;
    logic       rs_in;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] data_out;
    logic       rs_out;
    logic       enable_out;
    logic       busy;

    int         n_chk;
    int         n_pass;
    int         cyc;
    int         last_fall;
    int         hi_cnt;
    logic       e_prev;
    logic [4:0] bus_prev;
    logic [4:0] bus_rise;
    logic [4:0] got_q[$];
    logic [4:0] init_exp[$];

    lcd #(
        .CLK_FREQ_HZ  (12_000_000),
        .POWERUP_CYC  (P_POWERUP),
        .INIT1_CYC    (P_INIT1),
        .INIT2_CYC    (P_INIT2),
        .E_SETUP_CYC  (P_SETUP),
        .E_HIGH_CYC   (P_HIGH),
        .NIB_GAP_CYC  (P_GAP),
        .EXEC_CYC     (P_EXEC),
        .LONG_EXEC_CYC(P_LONG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_in     (rs_in),
        .start     (start),
        .data_in   (data_in),
        .data_out  (data_out),
        .rs_out    (rs_out),
        .enable_out(enable_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass = n_pass + 1;
    endtask

    // Pulse monitor: logs {rs,nibble} at every E rise and checks pulse shape.
    always @(negedge clk) begin
        e_prev   <= enable_out;
        bus_prev <= {rs_out, data_out};
        if (enable_out && !e_prev) begin
            got_q.push_back({rs_out, data_out});
            chk("setup_stable", 32'(bus_prev), 32'({rs_out, data_out}));
            bus_rise <= {rs_out, data_out};
            hi_cnt   <= 1;
        end else if (enable_out) begin
            hi_cnt <= hi_cnt + 1;
            chk("hold_in_e", 32'({rs_out, data_out}), 32'(bus_rise));
        end
        if (!enable_out && e_prev && rst) begin
            chk("e_high_width", 32'(hi_cnt), 32'(P_HIGH));
            last_fall <= cyc;
        end
    end

    function automatic int exp_busy_cyc(input logic r, input logic [7:0] b);
        int w;
        w = (!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? P_LONG : P_EXEC;
        return 1 + 2 * (P_SETUP + P_HIGH + P_GAP) + w;
    endfunction

    task automatic run_init();
        int n;
        int busy_fall;
        got_q.delete();
        rst = 1'b1;
        n   = 0;
        while (n < BOUND) begin
            @(posedge clk); #1;
            n = n + 1;
            start   = (n == 50 || n == P_POWERUP + 50);
            data_in = 8'($urandom);
            rs_in   = 1'($urandom);
            if (n == P_POWERUP) chk("no_e_in_powerup", 32'(got_q.size()), 32'(0));
            if (!busy) break;
        end
        start     = 1'b0;
        busy_fall = cyc;
        chk("init_done", 32'(busy), 32'(0));
        chk("init_pulses", 32'(got_q.size()), 32'(init_exp.size()));
        for (int i = 0; i < init_exp.size(); i++) begin
            if (i < got_q.size()) chk("init_nibble", 32'(got_q[i]), 32'(init_exp[i]));
        end
        chk("clear_wait", 32'(busy_fall - last_fall), 32'(P_GAP + P_LONG));
    endtask

    task automatic send(input logic r, input logic [7:0] b, input bit disturb);
        int n;
        n = 0;
        while (busy && n < BOUND) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        got_q.delete();
        start   = 1'b1;
        data_in = b;
        rs_in   = r;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = 8'($urandom);
        rs_in   = 1'($urandom);
        chk("busy_on_accept", 32'(busy), 32'(1));
        n = 0;
        while (busy && n < BOUND) begin
            @(posedge clk); #1;
            n = n + 1;
            if (disturb) start = (n == 5 || n == 100);
        end
        start = 1'b0;
        chk("accept_to_idle", 32'(n), 32'(exp_busy_cyc(r, b)));
        chk("byte_pulses", 32'(got_q.size()), 32'(2));
        if (got_q.size() >= 2) begin
            chk("high_nibble", 32'(got_q[0]), 32'({r, b[7:4]}));
            chk("low_nibble", 32'(got_q[1]), 32'({r, b[3:0]}));
        end
    endtask

    initial begin
        logic [7:0] init_bytes[4];
        logic [7:0] ib;
        logic [7:0] word[4];
        logic [7:0] rb;
        logic       rr;
        n_chk   = 0;
        n_pass  = 0;
        cyc     = 0;
        last_fall = 0;
        rst     = 1'b0;
        start   = 1'b0;
        data_in = 8'h00;
        rs_in   = 1'b0;

        init_bytes = '{8'h28, 8'h0C, 8'h06, 8'h01};
        init_exp.push_back(5'h03);
        init_exp.push_back(5'h03);
        init_exp.push_back(5'h03);
        init_exp.push_back(5'h02);
        for (int k = 0; k < 4; k++) begin
            ib = init_bytes[k];
            init_exp.push_back({1'b0, ib[7:4]});
            init_exp.push_back({1'b0, ib[3:0]});
        end

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_enable", 32'(enable_out), 32'(0));
        chk("rst_data", 32'(data_out), 32'(0));
        chk("rst_rs", 32'(rs_out), 32'(0));

        run_init();

        send(1'b1, 8'h48, 1'b0);
        word = '{8'h65, 8'h6C, 8'h6C, 8'h6F};
        for (int k = 0; k < 4; k++) send(1'b1, word[k], 1'b0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h03, 1'b1);

        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            rr = 1'($urandom);
            if (k == 2) begin
                rb = 8'($urandom_range(1, 3));
                rr = 1'b0;
            end
            send(rr, rb, k[0]);
        end

        // Abort a transfer while E is high, then expect the whole init to repeat.
        start   = 1'b1;
        data_in = 8'h5A;
        rs_in   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("e_before_abort", 32'(enable_out), 32'(1));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_enable", 32'(enable_out), 32'(0));
        chk("abort_busy", 32'(busy), 32'(1));
        repeat (3) begin
            @(posedge clk); #1;
        end
        run_init();
        send(1'b1, 8'h21, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
